fetch_stage: RTL and testbench

- Instruction-fetch stage directly downstream of the program counter in the VLIW core.
- Takes the current fetch address from the PC, reads the instruction-memory block RAM (1-cycle read latency) and presents {bundle, pc, valid} to decode.
- Absorbs decode back-pressure with a 2-entry buffer, so no bundle is lost or duplicated.
- Drives the PC's advance-enable and drops all in-flight work on a branch redirect.

---
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bus bundle between the fetch stage, instruction memory and decode.
//   imem_en/imem_addr -> instruction memory, imem_rdata <- (1-cycle read latency)
//   id_stall <- decode back-pressure
//   if_valid/if_inst/if_pc -> decode
// master: the fetch stage side. slave: the memory/decode side.
interface fetch_stage_if #(
  parameter int PC_W    = 25,
  parameter int IMEM_AW = 14,
  parameter int INST_W  = 128
);
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [INST_W-1:0]  imem_rdata;
  logic               id_stall;
  logic               if_valid;
  logic [INST_W-1:0]  if_inst;
  logic [PC_W-1:0]    if_pc;

  modport master (
    output imem_en, imem_addr, if_valid, if_inst, if_pc,
    input  imem_rdata, id_stall
  );
  modport slave (
    input  imem_en, imem_addr, if_valid, if_inst, if_pc,
    output imem_rdata, id_stall
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch directly downstream of the PC.
// Issues one imem read per cycle while there is room, captures the read data a
// cycle later into an output register backed by a one-entry skid, so decode
// back-pressure never loses or duplicates a bundle. A redirect flushes all
// in-flight work and lets the PC load its new target.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   pc_in            fetch address from the PC
//   pc_adv           PC advance/load enable
//   redirect         branch redirect, flushes the stage
//   bus (master)     imem read port + decode output (see fetch_stage_if)
//   perf_bubbles     cycles out of reset with if_valid=0   (FETCH_PERF_EN only)
//   perf_flushes     count of redirect cycles              (FETCH_PERF_EN only)
// Build option: define FETCH_PERF_EN to add the two performance counters.
module fetch_stage #(
  parameter int PC_W    = 25,
  parameter int IMEM_AW = 14,
  parameter int INST_W  = 128
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pc_in,
  output logic            pc_adv,
  input  logic            redirect,
  fetch_stage_if.master   bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_bubbles,
  output logic [31:0]     perf_flushes
`endif
);

  typedef struct packed {
    logic              vld;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } ent_t;

  ent_t            out_q, out_d, skid_q, skid_d, resp;
  logic            req_vld_q, req_vld_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic [1:0]      occ;
  logic            deq, issue;

  always_comb begin
    occ   = 2'(out_q.vld) + 2'(skid_q.vld) + 2'(req_vld_q);
    deq   = out_q.vld & ~bus.id_stall;
    // deq implies out_q.vld, so occ - deq cannot underflow.
    issue = rst_n & ~redirect & ((occ - 2'(deq)) < 2'd2);

    resp.vld  = req_vld_q;
    resp.inst = bus.imem_rdata;
    resp.pc   = req_pc_q;

    req_vld_d = issue;
    req_pc_d  = pc_in;
    out_d     = out_q;
    skid_d    = skid_q;

    if (redirect) begin
      out_d.vld  = 1'b0;
      skid_d.vld = 1'b0;
    end else if (deq) begin
      if (skid_q.vld) begin
        // Skid is older than the returning response: it goes out first and
        // the response (if any) refills the skid.
        out_d = skid_q;
        if (resp.vld) skid_d = resp;
        else          skid_d.vld = 1'b0;
      end else if (resp.vld) begin
        out_d = resp;
      end else begin
        out_d.vld = 1'b0;
      end
    end else if (resp.vld) begin
      // Issue throttling guarantees the skid is free when out is held.
      if (!out_q.vld) out_d  = resp;
      else            skid_d = resp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      skid_q    <= '0;
      req_vld_q <= 1'b0;
      req_pc_q  <= '0;
    end else begin
      out_q     <= out_d;
      skid_q    <= skid_d;
      req_vld_q <= req_vld_d;
      req_pc_q  <= req_pc_d;
    end
  end

  // The PC must still load its target on redirect even though nothing issues.
  assign pc_adv        = rst_n & (issue | redirect);
  assign bus.imem_en   = issue;
  assign bus.imem_addr = pc_in[IMEM_AW-1:0];
  assign bus.if_valid  = out_q.vld;
  assign bus.if_inst   = out_q.inst;
  assign bus.if_pc     = out_q.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] bub_q, bub_d, flush_q, flush_d;

  always_comb begin
    bub_d   = bub_q + 32'(~out_q.vld);
    flush_d = flush_q + 32'(redirect);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bub_q   <= '0;
      flush_q <= '0;
    end else begin
      bub_q   <= bub_d;
      flush_q <= flush_d;
    end
  end

  assign perf_bubbles = bub_q;
  assign perf_flushes = flush_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage.
// A queue of issued-but-not-consumed fetches is the reference: each entry
// becomes visible to decode two cycles after issue, is consumed on
// if_valid & !id_stall, and the whole queue is dropped on redirect/reset.
// Build option: define FETCH_PERF_EN to also check the perf counters.
module tb_fetch_stage;
  localparam int PC_W = 25, IMEM_AW = 14, INST_W = 128;

  logic            gclk = 1'b0;
  logic            rst_n;
  logic [PC_W-1:0] pc_in;
  logic            pc_adv;
  logic            redirect;
`ifdef FETCH_PERF_EN
  logic [31:0]     perf_bubbles, perf_flushes;
`endif

  fetch_stage_if #(.PC_W(PC_W), .IMEM_AW(IMEM_AW), .INST_W(INST_W)) bus ();

  fetch_stage #(.PC_W(PC_W), .IMEM_AW(IMEM_AW), .INST_W(INST_W)) dut (
    .clk      (gclk),
    .rst_n    (rst_n),
    .pc_in    (pc_in),
    .pc_adv   (pc_adv),
    .redirect (redirect),
    .bus      (bus.master)
`ifdef FETCH_PERF_EN
    ,
    .perf_bubbles (perf_bubbles),
    .perf_flushes (perf_flushes)
`endif
  );

  always #5 gclk = ~gclk;

  function automatic logic [INST_W-1:0] bundle(input logic [IMEM_AW-1:0] a);
    logic [31:0] x;
    x = {18'd0, a};
    return {x * 32'h9E3779B1, x * 32'h85EBCA6B + 32'd1, x ^ 32'hA5A55A5A, x * 32'hC2B2AE35};
  endfunction

  // instruction memory, 1-cycle read latency
  always @(posedge gclk)
    if (bus.imem_en) bus.imem_rdata <= bundle(bus.imem_addr);

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [INST_W-1:0] obs, input logic [INST_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, obs, exp);
    end
  endtask

  // reference model state
  logic [PC_W-1:0] q_pc[$];
  int              q_t[$];
  int              cyc;
  int              m_bub, m_flush;

  task automatic model_reset();
    q_pc.delete();
    q_t.delete();
    cyc = 0; m_bub = 0; m_flush = 0;
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic stall, input logic redir, input logic [PC_W-1:0] npc);
    logic ev, deq, iss;
    logic [PC_W-1:0] nxt;
    bus.id_stall = stall;
    redirect     = redir;
    #1;
    ev = (q_pc.size() > 0) && (q_t[0] + 2 <= cyc);
    chk("if_valid", bus.if_valid, ev);
    if (ev) begin
      chk("if_pc", bus.if_pc, q_pc[0]);
      chk("if_inst", bus.if_inst, bundle(q_pc[0][IMEM_AW-1:0]));
    end
    deq = ev && !stall;
    iss = !redir && ((q_pc.size() - int'(deq)) < 2);
    chk("imem_en", bus.imem_en, iss);
    chk("pc_adv", pc_adv, iss | redir);
    if (iss) chk("imem_addr", bus.imem_addr, pc_in[IMEM_AW-1:0]);
    if (!ev) m_bub++;
    if (redir) m_flush++;
    if (redir) begin
      q_pc.delete(); q_t.delete();
    end else begin
      if (deq) begin void'(q_pc.pop_front()); void'(q_t.pop_front()); end
      if (iss) begin q_pc.push_back(pc_in); q_t.push_back(cyc); end
    end
    nxt = redir ? npc : (iss ? pc_in + 1'b1 : pc_in);
    @(posedge gclk);
    #1;
    pc_in = nxt;
    cyc++;
    @(negedge gclk);
  endtask

  task automatic run_rand(input int n, input int stall_pct, input int redir_pct);
    for (int i = 0; i < n; i++)
      step($urandom_range(99) < stall_pct, $urandom_range(99) < redir_pct, PC_W'($urandom));
  endtask

`ifdef FETCH_PERF_EN
  task automatic chk_perf();
    chk("perf_bubbles", perf_bubbles, m_bub);
    chk("perf_flushes", perf_flushes, m_flush);
  endtask
`endif

  initial begin
    rst_n = 1'b0; pc_in = '0; redirect = 1'b1; bus.id_stall = 1'b0;
    model_reset();
    repeat (3) @(posedge gclk);
    #1;
    chk("rst_if_valid", bus.if_valid, 0);
    chk("rst_if_inst", bus.if_inst, 0);
    chk("rst_if_pc", bus.if_pc, 0);
    chk("rst_imem_en", bus.imem_en, 0);
    chk("rst_pc_adv", pc_adv, 0);
    @(negedge gclk);
    redirect = 1'b0;
    rst_n = 1'b1;

    // straight-line fetch
    repeat (8) step(0, 0, '0);
    // stall three cycles, then release
    repeat (3) step(1, 0, '0);
    repeat (6) step(0, 0, '0);
    // redirect while streaming
    step(0, 1, PC_W'(40));
    repeat (5) step(0, 0, '0);
`ifdef FETCH_PERF_EN
    chk_perf();
`endif
    // redirect while full and stalled
    repeat (3) step(1, 0, '0);
    step(1, 1, PC_W'(100));
    repeat (5) step(0, 0, '0);

    run_rand(2000, 30, 5);
`ifdef FETCH_PERF_EN
    chk_perf();
`endif

    // asynchronous reset with the buffer full
    repeat (3) step(1, 0, '0);
    bus.id_stall = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_if_valid", bus.if_valid, 0);
    chk("mid_rst_imem_en", bus.imem_en, 0);
    chk("mid_rst_pc_adv", pc_adv, 0);
    pc_in = '0;
    repeat (2) @(negedge gclk);
    model_reset();
    rst_n = 1'b1;
    run_rand(500, 30, 5);
`ifdef FETCH_PERF_EN
    chk_perf();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
